// File: rtl/feaddsub.sv
`default_nettype none
// =============================================================================
// feaddsub : limb-serial modular adder/subtractor over p = 2^W - C (rev 1.0)
// =============================================================================
module feaddsub #(
  parameter int W    = 255,
  parameter int C    = 19,
  parameter int LIMB = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_out
);

  localparam int NLIMB = (W + LIMB - 1) / LIMB;
  localparam int WP    = NLIMB * LIMB;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [WP-1:0] c_P = ({WP{1'b1}} >> (WP - W)) - WP'(C - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SEL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [WP-1:0]   r_a, r_b, r_p;
  logic [WP-1:0]   r_x, r_y;
  logic            r_op;
  logic            r_c1;
  logic [1:0]      r_c2;
  logic            r_busy, r_done;
  logic [W-1:0]    r_out;

  logic [LIMB-1:0] w_al, w_bl, w_pl;
  logic [LIMB:0]   w_x;
  logic [LIMB+1:0] w_y;
  logic            w_last;
  logic            w_sel_y;
  logic [W-1:0]    w_res;

  // Both chains are single three-input adders: chain 1 is a +/- b, chain 2
  // folds the modulus in directly (a + b - p, or a - b + p) so no chain waits
  // on the other. Operands are zero-padded to WP bits; the inverted padding
  // makes each subtraction a proper two's complement over WP bits.
  always_comb begin
    w_al    = LIMB'(r_a);
    w_bl    = r_op ? ~LIMB'(r_b) : LIMB'(r_b);
    w_pl    = r_op ? LIMB'(r_p) : ~LIMB'(r_p);
    w_x     = {1'b0, w_al} + {1'b0, w_bl} + {{LIMB{1'b0}}, r_c1};
    w_y     = {2'b00, w_al} + {2'b00, w_bl} + {2'b00, w_pl} + {{LIMB{1'b0}}, r_c2};
    w_last  = (r_idx == IW'(NLIMB - 1));
    // add: carry out of a+b-p means s >= p; sub: no carry out of a-b means a < b
    w_sel_y = r_op ? ~r_c1 : (r_c2 != 2'd0);
    w_res   = w_sel_y ? W'(r_y) : W'(r_x);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_SEL;
      S_SEL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_op   <= 1'b0;
      r_c1   <= 1'b0;
      r_c2   <= 2'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a   <= WP'(i_a);
            r_b   <= WP'(i_b);
            r_p   <= c_P;
            r_op  <= i_op;
            r_idx <= '0;
            r_c1  <= i_op;
            r_c2  <= 2'd1;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> LIMB;
          r_b   <= r_b >> LIMB;
          r_p   <= r_p >> LIMB;
          r_c1  <= w_x[LIMB];
          r_c2  <= w_y[LIMB+1:LIMB];
          r_x   <= WP'({w_x[LIMB-1:0], r_x} >> LIMB);
          r_y   <= WP'({w_y[LIMB-1:0], r_y} >> LIMB);
          r_idx <= r_idx + 1'b1;
        end
        S_SEL: begin
          r_out  <= w_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_feaddsub.sv
`default_nettype none
// Testbench for feaddsub: default curve25519 instance plus a W=8, C=5, LIMB=3
// instance, checked against a plain-arithmetic modular reference.
module tb_feaddsub;

  localparam logic [255:0] P0 = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] P1 = 256'd251;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s0, op0, s1, op1;
  logic [254:0] a0, b0;
  logic [7:0]   a1, b1;
  logic         busy0, done0, busy1, done1;
  logic [254:0] out0;
  logic [7:0]   out1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  feaddsub dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s0), .i_op(op0), .i_a(a0), .i_b(b0),
    .o_busy(busy0), .o_done(done0), .o_out(out0)
  );

  feaddsub #(.W(8), .C(5), .LIMB(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s1), .i_op(op1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_out(out1)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_mod(input logic [255:0] a, input logic [255:0] b,
                                           input logic op, input logic [255:0] p);
    logic [256:0] s;
    if (!op) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, p}) s = s - {1'b0, p};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, p} - {1'b0, b};
    end
    return s[255:0];
  endfunction

  function automatic logic [255:0] rnd_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    if (r >= P0) r = r - P0;
    return r;
  endfunction

  task automatic scramble();
    logic [255:0] t;
    t = rnd_fe(); a0 = t[254:0];
    t = rnd_fe(); b0 = t[254:0];
    t = rnd_fe(); a1 = t[7:0]; b1 = t[15:8]; op0 = t[16]; op1 = t[17];
  endtask

  task automatic do_op(input bit sm, input logic [255:0] a, input logic [255:0] b,
                       input logic op, input string tag);
    logic [255:0] exp, o;
    int  n, nb;
    bit  got;
    logic bz;
    exp = ref_mod(a, b, op, sm ? P1 : P0);
    @(negedge clk);
    if (sm) begin a1 = a[7:0]; b1 = b[7:0]; op1 = op; s1 = 1'b1; end
    else    begin a0 = a[254:0]; b0 = b[254:0]; op0 = op; s0 = 1'b1; end
    @(posedge clk); #1;
    s0 = 1'b0; s1 = 1'b0;
    scramble();
    n = 0; nb = 0; got = 1'b0; bz = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (sm ? done1 : done0) begin
        got = 1'b1;
        bz  = sm ? busy1 : busy0;
      end else if (sm ? busy1 : busy0) begin
        nb++;
      end
    end
    o = sm ? {248'd0, out1} : {1'b0, out0};
    check_eq({tag, " done seen"}, 256'(got), 256'd1);
    check_eq({tag, " out"}, o, exp);
    check_eq({tag, " latency"}, 256'(n), sm ? 256'd4 : 256'd5);
    check_eq({tag, " busy cycles"}, 256'(nb), sm ? 256'd3 : 256'd4);
    check_eq({tag, " busy at done"}, 256'(bz), 256'd0);
    @(posedge clk); #1;
    check_eq({tag, " done pulse width"}, 256'(sm ? done1 : done0), 256'd0);
  endtask

  initial begin
    logic [255:0] va[3], vb[3], vx[3], last, x, y;
    logic         vop[3];
    int           nd, cnt;

    rst_n = 1'b0; s0 = 1'b0; s1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #12;
    check_eq("reset busy", 256'(busy0), 256'd0);
    check_eq("reset done", 256'(done0), 256'd0);
    check_eq("reset out", {1'b0, out0}, 256'd0);
    check_eq("reset out small", {248'd0, out1}, 256'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 256'd15, 256'd7, 1'b0, "add 15+7");
    check_eq("add 15+7 value", {1'b0, out0}, 256'd22);
    do_op(0, 256'd1 << 254, 256'd1 << 254, 1'b0, "add 2^254+2^254");
    check_eq("add 2^254 value", {1'b0, out0}, 256'd19);
    do_op(0, (256'd1 << 255) - 256'd20, 256'd1, 1'b0, "add to p");
    do_op(0, 256'd7, 256'd15, 1'b1, "sub 7-15");
    check_eq("sub 7-15 value", {1'b0, out0}, (256'd1 << 255) - 256'd27);
    do_op(0, 256'd15, 256'd7, 1'b1, "sub 15-7");
    x = rnd_fe();
    do_op(0, x, x, 1'b1, "sub x-x");
    do_op(0, P0 - 256'd1, P0 - 256'd1, 1'b0, "add max+max");
    do_op(0, 256'd0, P0 - 256'd1, 1'b1, "sub 0-max");
    for (int i = 0; i < 12; i++) begin
      x = rnd_fe(); y = rnd_fe();
      do_op(0, x, y, 1'($urandom), "rand big");
    end

    // start held high with op toggling; random start/bus noise while busy
    for (int j = 0; j < 3; j++) begin
      va[j] = rnd_fe(); vb[j] = rnd_fe(); vop[j] = 1'(j % 2);
      vx[j] = ref_mod(va[j], vb[j], vop[j], P0);
    end
    @(negedge clk);
    a0 = va[0][254:0]; b0 = vb[0][254:0]; op0 = vop[0]; s0 = 1'b1;
    nd = 0; last = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        if (nd < 3) check_eq("hold out", {1'b0, out0}, vx[nd]);
        last = {1'b0, out0};
        nd++;
        if (nd < 3) begin
          a0 = va[nd][254:0]; b0 = vb[nd][254:0]; op0 = vop[nd]; s0 = 1'b1;
        end else begin
          s0 = 1'b0;
        end
      end else begin
        if (nd > 0) check_eq("hold out stable", {1'b0, out0}, last);
        if (nd < 3) begin
          scramble();
          s0 = 1'($urandom);
        end
      end
    end
    check_eq("hold done count", 256'(nd), 256'd3);

    // abort mid-RUN at limb 2
    do_op(0, 256'd40, 256'd3, 1'b0, "pre-abort add");
    @(negedge clk);
    a0 = 255'd9; b0 = 255'd4; op0 = 1'b0; s0 = 1'b1;
    @(posedge clk); #1; s0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 256'(busy0), 256'd0);
    check_eq("abort done", 256'(done0), 256'd0);
    check_eq("abort out", {1'b0, out0}, 256'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done0) cnt++;
    end
    check_eq("no done after abort", 256'(cnt), 256'd0);
    do_op(0, 256'd1, 256'd1, 1'b0, "post-reset 1+1");
    check_eq("post-reset value", {1'b0, out0}, 256'd2);

    // partial top limb instance
    do_op(1, 256'd250, 256'd250, 1'b0, "small 250+250");
    check_eq("small 250+250 value", {248'd0, out1}, 256'd249);
    do_op(1, 256'd3, 256'd5, 1'b1, "small 3-5");
    check_eq("small 3-5 value", {248'd0, out1}, 256'd249);
    do_op(1, 256'd200, 256'd51, 1'b0, "small 200+51");
    check_eq("small 200+51 value", {248'd0, out1}, 256'd0);
    for (int i = 0; i < 8; i++) begin
      x = 256'($urandom_range(0, 250)); y = 256'($urandom_range(0, 250));
      do_op(1, x, y, 1'($urandom), "rand small");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/feaddsub.md
# feaddsub

Multi-cycle modular adder/subtractor over the prime field p = 2^W − C; default is the curve25519 field, 2^255 − 19. It is the parametrised successor of the fixed-width field adder:
- generic W, C and limb width;
- runtime add/sub select;
- limb-serial carry chain, so the critical path is one LIMB-bit adder;
- start/done handshake with a busy flag.

It sits beside the field multiplier in the point-arithmetic datapath and produces canonical results.

## Interface
- W, default 255: operand/result width.
- C, default 19: modulus offset, p = 2^W − C. Legal range 1 ≤ C < 2^(W−1).
- LIMB, default 64: bits processed per cycle. NLIMB = ceil(W/LIMB); the top limb may be partial.
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a rising edge only while idle.
- op  input  1  0 = add (a + b mod p), 1 = subtract (a − b mod p); captured with start.
- a  input  W  operand, captured with start.
- b  input  W  operand, captured with start.
- busy  output  1  high from the edge after an accepted start until the result edge.
- done  output  1  one-cycle pulse; out is valid and the result is new.
- out  output  W  result; holds its value until the next result or reset.

## Operation
States:
- IDLE: start=1 latches a, b, op, clears limb index and carries, and goes to RUN. start=0 stays in IDLE.
- RUN: each cycle processes limb i (bits i·LIMB upward) through two chains in parallel.
  - Add: chain 1 is s = a + b; chain 2 is t = s − p.
  - Sub: chain 1 is d = a − b; chain 2 is u = d + p.
  - Each chain has its own carry/borrow register. Limb results are stored into two W-bit candidate registers.
  - After limb NLIMB−1, go to SEL.
- SEL: pick a candidate, register it into out, set done=1 for one cycle, return to IDLE.
  - Add: out = t if s ≥ p, else s. Here s is the (W+1)-bit sum, and "s ≥ p" means chain 2 produced no final borrow.
  - Sub: out = u if chain 1 produced a final borrow (a < b), else d. The value is truncated to W bits.

Arithmetic and width rules:
- Inputs are required to be canonical (< p); outputs are then canonical (< p).
- Non-canonical inputs still get deterministically exactly the single conditional correction above; no second reduction.
- p's limbs are constants derived from W and C. No runtime modulus.
- The top limb uses only W mod LIMB bits (all LIMB bits if that is 0). The add carry out of bit W−1 is bit W of s and feeds the s ≥ p decision.

Boundary rules:
- start while busy or in SEL is ignored. No queueing. The captured operands are unaffected.
- The input buses may change freely after the accepting edge.
- a = b and op = 1 gives 0. a + b = p exactly gives 0.
- reset_n low at any time, including mid-RUN, immediately forces IDLE, busy=0, done=0, out=0, and clears all carries and candidates. The aborted operation never produces done.
- The first start after reset release is accepted normally.

## Timing
- Reset values: busy=0, done=0, out=0.
- start sampled high at edge k:
  - RUN occupies edges k+1 … k+NLIMB;
  - SEL registers out and done at edge k+NLIMB+1;
  - done is high for exactly one cycle.
- Latency is NLIMB+1 edges (5 for defaults).
- busy is high from edge k+1 until edge k+NLIMB+1, when it falls in the same edge that done rises.
- A start held high during the done cycle is accepted at the next edge. Back-to-back throughput is one result per NLIMB+2 cycles.
- A continuously high start restarts on every idle edge.

## Test plan
- Defaults, add 15 + 7: out=22. done exactly 5 edges after the start edge. busy high for 4 cycles before done.
- Add 2^254 + 2^254: out=19. Add (2^255−20) + 1: out=0. Add 0x6483b328…f1fa20de + 0x7579007f…d33d4b0a: out=0x59fcb3a7…c5376bfb.
- Sub 7 − 15: out=2^255−27 (0x7fff…ffe5). Sub 15 − 7: out=8. Sub x − x: out=0.
- Hold start and op toggling through three operations with start pulses during busy:
  - pulses during busy are ignored;
  - exactly three done pulses with the correct results in order;
  - out is stable between pulses.
- Assert reset_n low at RUN limb 2: outputs are 0 immediately and no done follows. After release, add 1 + 1 gives out=2 with normal latency.
- W=8, C=5, LIMB=3 (p=251, NLIMB=3, partial top limb):
  - 250 + 250 gives 249;
  - 3 − 5 gives 249;
  - 200 + 51 gives 0;
  - done 4 edges after start.
